// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// request record and the access-size / legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_WAIT0,
        ST_BEAT1,
        ST_WAIT1,
        ST_RESP
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Access size in bytes (1, 2 or 4).
    function automatic logic [2:0] size_from_f3(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load merge: shifts the {hi, lo} word pair down to the access
// offset and sign- or zero-extends the selected bytes.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] win;

    assign win = 32'({hi, lo} >> {off, 3'b000});

    always_comb begin
        case (funct3)
            F3_B:    rdata = {{24{win[7]}}, win[7:0]};
            F3_BU:   rdata = {24'b0, win[7:0]};
            F3_H:    rdata = {{16{win[15]}}, win[15:0]};
            F3_HU:   rdata = {16'b0, win[15:0]};
            default: rdata = win;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit: turns one request at a time into one or two
// word-aligned memory beats and returns a single completion.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    lsu_state_e  state;
    lsu_req_t    req_q;
    lsu_req_t    src;
    logic [31:0] lo_q;

    logic [2:0]  size;
    logic [1:0]  off;
    logic [3:0]  mask;
    logic [7:0]  be_full;
    logic [63:0] wd_full;
    logic        split;
    logic        err;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] align_lo;
    logic [31:0] align_out;

    // Lane geometry comes from the incoming request while idle and from the
    // registered copy once the access is in flight.
    always_comb begin
        if (state == ST_IDLE) begin
            src.we     = req_we;
            src.funct3 = req_funct3;
            src.addr   = req_addr;
            src.wdata  = req_wdata;
        end else begin
            src = req_q;
        end
        size = size_from_f3(src.funct3);
        off  = src.addr[1:0];
        case (size)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        be_full = {4'b0000, mask} << off;
        wd_full = {32'b0, src.wdata} << {off, 3'b000};
        split   = |be_full[7:4];
        err     = !f3_legal(src.we, src.funct3) || (split && !MISALIGN_EN);
        addr0   = {src.addr[31:2], 2'b00};
        addr1   = addr0 + 32'd4;
    end

    // The word arriving this cycle is merged directly, so the completion
    // data is registered on the same edge that enters RESP.
    assign align_lo = (state == ST_WAIT0) ? mem_rdata : lo_q;

    lsu_load_align u_align (
        .lo     (align_lo),
        .hi     (mem_rdata),
        .off    (req_q.addr[1:0]),
        .funct3 (req_q.funct3),
        .rdata  (align_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            lo_q      <= '0;
            req_ready <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        req_q     <= src;
                        if (err) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= ST_BEAT0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= addr0;
                            mem_be    <= be_full[3:0];
                            mem_wdata <= req_we ? wd_full[31:0] : 32'b0;
                        end
                    end
                end
                ST_BEAT0: begin
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        if (!req_q.we) begin
                            state <= ST_WAIT0;
                        end else if (split) begin
                            state     <= ST_BEAT1;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr1;
                            mem_be    <= be_full[7:4];
                            mem_wdata <= wd_full[63:32];
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                ST_WAIT0: begin
                    if (mem_rvalid) begin
                        lo_q <= mem_rdata;
                        if (split) begin
                            state    <= ST_BEAT1;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= addr1;
                            mem_be   <= be_full[7:4];
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= align_out;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        if (req_q.we) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state <= ST_WAIT1;
                        end
                    end
                end
                ST_WAIT1: begin
                    if (mem_rvalid) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= align_out;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit that sits directly upstream of the byte-addressed data memory and drives it.
- Accepts one RV32I load/store request at a time from the execute stage.
- Converts each request into word-aligned memory beats with byte enables; a misaligned access that crosses a word boundary is split into two beats.
- Merges, sign-extends or zero-extends load data and returns one completion per request.

Parameters:
- MISALIGN_EN, 1: 1 = split word-crossing accesses into two beats; 0 = report them as an error with no memory access.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- mem_req  out  1  memory beat request.
- mem_gnt  in  1  memory accepts the beat this cycle.
- mem_we  out  1  beat is a write.
- mem_addr  out  32  word address; bits [1:0] are always 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-shifted write data.
- mem_rvalid  in  1  read data valid; arrives at least 1 cycle after its grant.
- mem_rdata  in  32  read word.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal funct3, or misaligned access with MISALIGN_EN=0.

Behaviour:
- Reset: asynchronous, active-low. All outputs 0 and FSM in IDLE. req_ready rises the first cycle after rst_n deasserts.
- Reset asserted mid-operation aborts the access. A partial store may already be committed. Any mem_rvalid arriving while in IDLE is ignored.
- Sizing: size = 1, 2 or 4 bytes. off = addr[1:0]. Access crosses a word when off + size > 4, i.e. LH/SH at off=3, or LW/SW at off≠0.
- Illegal encodings are funct3 011, 110, 111 (loads) and anything other than 000/001/010 (stores). On accept these go to RESP with rsp_err=1 and no memory beat. Misaligned accesses with MISALIGN_EN=0 are handled the same way.
- FSM states: IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP.
  - IDLE: on req_valid && req_ready, register the request and go to BEAT0 (or RESP on error).
  - BEAT0: hold mem_req=1 with stable addr/be/wdata until mem_gnt.
    - On grant, a store goes to BEAT1 if split, else RESP.
    - On grant, a load goes to WAIT0.
  - WAIT0: on mem_rvalid, latch the low word, then go to BEAT1 if split, else RESP.
  - BEAT1: beat at word address + 4; on grant, a store goes to RESP and a load goes to WAIT1.
  - WAIT1: on mem_rvalid, latch the high word and go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Only one memory beat is outstanding at a time.
- Byte lanes:
  - Beat0 be = ((1<<size)-1) << off, truncated to 4 bits. Beat1 be = the overflow bits >> 4.
  - Beat0 wdata = req_wdata << (8*off). Beat1 wdata = req_wdata >> (8*(4-off)).
- Load merge: form the 64-bit value {hi, lo}, shift right by 8*off, take the low `size` bytes, then sign- or zero-extend per funct3.
- Latency with a zero-wait memory (grant in the request cycle, rvalid the next cycle), counted from accept cycle T:
  - aligned store: rsp_valid at T+2.
  - aligned load: rsp_valid at T+3.
  - split store: rsp_valid at T+3.
  - split load: rsp_valid at T+5.
  - error: rsp_valid at T+1.
- A new request can be accepted in the cycle after RESP.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B/H/W/BU/HU).
  - FSM state encoding.
  - a size-from-funct3 function.
  - the legality check.
- One sub-module, lsu_load_align: combinational 64-bit merge, shift and extend. It is reused by the pipelined core's MEM stage.

Test Plan:
- Aligned SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> beat be=1111 at 0x10; load rsp_rdata=0xDEADBEEF, rsp_err=0.
- SB 0x13 data 0x80, then LB 0x13 / LBU 0x13 -> be=1000, wdata=0x80000000; rsp_rdata 0xFFFFFF80 / 0x00000080.
- SH 0x07 data 0xA55A (split), then LH 0x07 -> beats at 0x04 be=1000 and 0x08 be=0001; rsp_rdata=0xFFFFA55A at T+5.
- LW 0x0E with MISALIGN_EN=0 -> no mem_req; rsp_valid at T+1 with rsp_err=1 and rsp_rdata=0.
- mem_gnt withheld 3 cycles on a store -> mem_addr/be/wdata stable throughout; req_ready=0 until after RESP.
- rst_n pulled low while in WAIT0, then mem_rvalid=1 next cycle -> no rsp_valid; all outputs 0; req_ready=1 after release.
